// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes the keyboard clock/data lines, decodes
// 11-bit frames (start, 8 data LSB first, odd parity, stop) and buffers good
// scan codes behind a valid/ready handshake.
// Build option: define PS2_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a
// single holding register is used with the same handshake.
module ps2_keyboard_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 16000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_error,
  output logic       overflow
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic            clk_s1, clk_s2, clk_prev;
  logic            data_s1, data_s2;
  logic            fall;

  state_t          state, state_nxt;
  logic [2:0]      bit_cnt, bit_cnt_nxt;
  logic [7:0]      shift, shift_nxt;
  logic            parity_bit, parity_bit_nxt;
  logic [WD_W-1:0] wd, wd_nxt;
  logic            push, frame_err;

  logic            pop, full, accept;

  // Two-stage synchronizers plus a delayed copy of the clock for edge detection
  always_ff @(posedge CLK) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // Frame decoder state register
  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      wd         <= '0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift      <= shift_nxt;
      parity_bit <= parity_bit_nxt;
      wd         <= wd_nxt;
    end
  end

  // Frame decoder next-state: bit sampling on falling edges, watchdog otherwise
  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    shift_nxt      = shift;
    parity_bit_nxt = parity_bit;
    wd_nxt         = wd;
    push           = 1'b0;
    frame_err      = 1'b0;
    if (state == IDLE) begin
      wd_nxt = '0;
      if (fall && !data_s2) begin
        state_nxt   = DATA;
        bit_cnt_nxt = '0;
      end
    end else if (fall) begin
      wd_nxt = '0;
      unique case (state)
        DATA: begin
          shift_nxt   = {data_s2, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_nxt = PARITY;
          end
        end
        PARITY: begin
          parity_bit_nxt = data_s2;
          state_nxt      = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          if (data_s2 && ((^shift) ^ parity_bit)) begin
            push = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (wd == WD_LAST) begin
      state_nxt = IDLE;
      wd_nxt    = '0;
      frame_err = 1'b1;
    end else begin
      wd_nxt = wd + 1'b1;
    end
  end

  assign pop    = rx_valid & rx_ready;
  // A pop in the same cycle frees the slot, so a push into a full buffer still lands
  assign accept = push & (~full | pop);

  // Registered one-cycle status pulses
  always_ff @(posedge CLK) begin
    if (reset) begin
      rx_error <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rx_error <= frame_err;
      overflow <= push & full & ~pop;
    end
  end

`ifdef PS2_RX_FIFO_EN
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [7:0]    last_rd;

  assign full     = (count == FULL_CNT);
  assign rx_valid = (count != '0);
  // When empty, present the most recently consumed byte rather than a stale slot
  assign rx_data  = rx_valid ? mem[rd_ptr] : last_rd;

  // FIFO storage, pointers and occupancy
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      last_rd <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        last_rd <= mem[rd_ptr];
      end
      unique case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
`else
  logic [7:0] hold;
  logic       hold_full;

  assign full     = hold_full;
  assign rx_valid = hold_full;
  assign rx_data  = hold;

  // Single holding register; contents persist after the pop
  always_ff @(posedge CLK) begin
    if (reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      if (accept) begin
        hold <= shift;
      end
      hold_full <= accept | (hold_full & ~pop);
    end
  end
`endif

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: scoreboard of expected bytes,
// error/overflow pulse timing checks, timeout, buffer-full and reset cases.
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;

  localparam int unsigned HALF    = 8;
  localparam int unsigned TIMEOUT = 16000;
`ifdef PS2_RX_FIFO_EN
  localparam int unsigned DEPTH = 4;
`else
  localparam int unsigned DEPTH = 1;
`endif

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int ovf_seen = 0;
  int exp_err = 0;
  int exp_ovf = 0;
  logic [7:0] sb[$];

  ps2_keyboard_rx #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .FIFO_DEPTH(4)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_error(rx_error),
    .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: count pulses and compare every handshake against the queue
  always @(negedge CLK) begin
    if (!reset) begin
      if (rx_error) err_seen++;
      if (overflow) ovf_seen++;
      if (rx_valid && rx_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_byte", {24'h0, rx_data}, 32'hFFFF_FFFF);
        end else begin
          check("rx_data", {24'h0, rx_data}, {24'h0, sb.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    repeat (HALF) tick();
    ps2_clk = 1'b0;
    repeat (HALF) tick();
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input logic keep, input logic exp_ov, input logic pop_at_push);
    logic good;
    good = stp & ((^b) ^ par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    if (good && keep) sb.push_back(b);
    if (!good) exp_err++;
    if (exp_ov) exp_ovf++;
    ps2_data = stp;
    repeat (HALF) tick();
    ps2_clk = 1'b0;
    tick();
    tick();
    check("err_early", {31'h0, rx_error}, 32'h0);
    if (pop_at_push) rx_ready = 1'b1;
    tick();
    check("err_pulse", {31'h0, rx_error}, {31'h0, ~good});
    check("ovf_pulse", {31'h0, overflow}, {31'h0, exp_ov});
    if (pop_at_push) rx_ready = 1'b0;
    tick();
    check("err_width", {31'h0, rx_error}, 32'h0);
    check("ovf_width", {31'h0, overflow}, 32'h0);
    repeat (HALF - 4) tick();
    ps2_clk = 1'b1;
    repeat (HALF) tick();
    ps2_data = 1'b1;
  endtask

  task automatic good_frame(input logic [7:0] b, input logic keep, input logic exp_ov,
                            input logic pop_at_push);
    send_frame(b, ~(^b), 1'b1, keep, exp_ov, pop_at_push);
  endtask

  task automatic drain();
    int n;
    n = 0;
    rx_ready = 1'b1;
    while (rx_valid && n < 200) begin
      tick();
      n++;
    end
    check("drain_valid", {31'h0, rx_valid}, 32'h0);
  endtask

  initial begin
    logic [7:0] pats [4];
    int n;
    pats = '{8'h00, 8'hFF, 8'hA5, 8'h80};

    repeat (3) tick();
    check("rst_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_data", {24'h0, rx_data}, 32'h0);
    check("rst_err", {31'h0, rx_error}, 32'h0);
    check("rst_ovf", {31'h0, overflow}, 32'h0);
    reset = 1'b0;
    repeat (4) tick();

    // basic reception and framing errors
    rx_ready = 1'b1;
    good_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    foreach (pats[i]) good_frame(pats[i], 1'b1, 1'b0, 1'b0);
    check("err_count_a", err_seen, exp_err);
    check("sb_empty_a", sb.size(), 0);

    // abandoned frame: start plus three data bits, then silence
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    exp_err++;
    n = 0;
    while (!rx_error && n < int'(TIMEOUT) + 100) begin
      tick();
      n++;
    end
    check("tout_seen", {31'h0, rx_error}, 32'h1);
    check("tout_time", {31'h0, (n >= int'(TIMEOUT - HALF) - 10) && (n <= int'(TIMEOUT - HALF) + 10)}, 32'h1);
    tick();
    check("tout_width", {31'h0, rx_error}, 32'h0);
    good_frame(8'hF0, 1'b1, 1'b0, 1'b0);
    check("err_count_b", err_seen, exp_err);

    // fill the buffer, one extra byte overflows
    rx_ready = 1'b0;
    for (int k = 1; k <= int'(DEPTH) + 1; k++) begin
      good_frame(8'(k), k <= int'(DEPTH), k == int'(DEPTH) + 1, 1'b0);
    end
    check("full_valid", {31'h0, rx_valid}, 32'h1);
    drain();
    check("empty_hold", {24'h0, rx_data}, DEPTH);
    check("sb_empty_b", sb.size(), 0);

    // full buffer with a pop coinciding with the push
    rx_ready = 1'b0;
    for (int k = 1; k <= int'(DEPTH); k++) begin
      good_frame(8'h10 + 8'(k), 1'b1, 1'b0, 1'b0);
    end
    good_frame(8'h55, 1'b1, 1'b0, 1'b1);
    drain();
    check("last_is_55", {24'h0, rx_data}, 32'h55);
    check("sb_empty_c", sb.size(), 0);

    // reset in the middle of a frame
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("midrst_valid", {31'h0, rx_valid}, 32'h0);
    good_frame(8'h2A, 1'b1, 1'b0, 1'b0);

    repeat (20) tick();
    check("sb_empty_end", sb.size(), 0);
    check("err_total", err_seen, exp_err);
    check("ovf_total", ovf_seen, exp_ovf);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16000, is the number of idle CLK cycles (1 ms at 16 MHz) after which a partial frame is abandoned.
REQ-002 Parameter FIFO_DEPTH, default 4 (power of two), is the number of received-byte entries held when PS2_RX_FIFO_EN is defined.
REQ-003 Port CLK  input  1  is the 16 MHz system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  is a synchronous, active-high reset.
REQ-005 Port ps2_clk  input  1  is the keyboard clock (PIN_13), asynchronous to CLK and idle-high.
REQ-006 Port ps2_data  input  1  is the keyboard data (PIN_12), asynchronous to CLK and idle-high.
REQ-007 Port rx_data  output  8  is the scan-code byte at the buffer head.
REQ-008 Port rx_valid  output  1  is high while the buffer is non-empty.
REQ-009 Port rx_ready  input  1  is the consumer accept; a byte is popped in any cycle where rx_valid and rx_ready are both high.
REQ-010 Port rx_error  output  1  is a one-cycle pulse on a parity, stop-bit or timeout error.
REQ-011 Port overflow  output  1  is a one-cycle pulse when a good byte is dropped because the buffer is full.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-FF synchronizer; a falling edge is sync_clk_prev=1 and sync_clk=0.
REQ-013 The FSM SHALL have the states IDLE, DATA, PARITY and STOP, and it SHALL sample synchronized data only on detected falling edges.
REQ-014 In IDLE, a falling edge with data=0 (start bit) SHALL go to DATA with bit_cnt=0; a falling edge with data=1 SHALL be ignored.
REQ-015 DATA SHALL shift in 8 bits LSB first and go to PARITY after the 8th bit.
REQ-016 PARITY SHALL capture the parity bit and go to STOP.
REQ-017 STOP SHALL always return to IDLE; the byte is good only if stop=1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity).
REQ-018 A good byte SHALL be pushed at the clock edge that processes the stop-bit falling edge; rx_valid therefore rises 3 CLK edges after the first edge that samples ps2_clk low.
REQ-019 A bad parity or stop bit SHALL discard the byte and pulse rx_error for exactly one cycle.
REQ-020 In any non-IDLE state, a watchdog SHALL count CLK cycles, clearing on each falling edge.
REQ-021 When the watchdog reaches TIMEOUT_CYCLES-1, the FSM SHALL go to IDLE, discard the frame and pulse rx_error once.
REQ-022 The buffer SHALL be FIFO-ordered, with rx_data showing the head combinationally from the register array.
REQ-023 rx_data SHALL be 0 after reset, and it SHALL hold the last-read value when empty.
REQ-024 A push while full without a same-cycle pop SHALL drop the new byte, keep the contents unchanged and pulse overflow.
REQ-025 A push and a pop in the same cycle while full SHALL both take effect, with no overflow and occupancy unchanged.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH, and the occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-027 rx_error and overflow MAY pulse in the same cycle, and the two are independent.

Reset
REQ-028 With reset high at a CLK edge: FSM=IDLE; bit_cnt, watchdog, pointers and occupancy=0; the shift register=0.
REQ-029 Synchronizer FFs SHALL reset to 1, and rx_data, rx_valid, rx_error and overflow SHALL all be 0.
REQ-030 Reset mid-frame SHALL discard the partial frame with no rx_error pulse, and reception SHALL resume at the next start bit after reset deasserts.

Configuration
REQ-031 If PS2_RX_FIFO_EN is defined, the buffer SHALL be a FIFO_DEPTH-entry FIFO.
REQ-032 If PS2_RX_FIFO_EN is undefined, the buffer SHALL be a single holding register (depth 1) with the same handshake; a second good byte before the pop is dropped with overflow, and a same-cycle pop-and-push is accepted.

Verification
REQ-033 Frame 0x1C with parity 0 and stop 1, rx_ready=1 -> one rx_valid beat with rx_data=0x1C; rx_error=0.
REQ-034 Frame 0x1C with parity 1 -> no rx_valid, and one rx_error pulse 3 cycles after the stop falling edge.
REQ-035 Start bit plus 3 data bits, then ps2_clk held high for 16000 cycles -> one rx_error pulse and FSM=IDLE; a following frame 0xF0 with parity 1 is received as 0xF0.
REQ-036 With PS2_RX_FIFO_EN defined and rx_ready=0, frames 0x01..0x05 -> overflow pulses once, on the 5th byte; popping then yields 0x01, 0x02, 0x03, 0x04 and rx_valid falls.
REQ-037 FIFO full with rx_ready=1 timed to coincide with a push of 0x55 -> no overflow; 0x55 is read last.
REQ-038 reset asserted for 1 cycle after the 4th data bit of a frame -> no rx_valid and no rx_error; the next frame 0x2A with parity 0 is received correctly.
